// File: rtl/clock_pkg.sv
// Shared clock constants: mode encodings, digit limits, hour range.
// Used by the time counter, display mux and increment selector.
package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_MIN = 2'b01;
    localparam logic [1:0] MODE_SET_HR  = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    localparam int DIGIT_MAX     = 9;
    localparam int SEC_TENS_MAX  = 5;
    localparam int MIN_TENS_MAX  = 5;
    localparam int HOURS_MAX_DEF = 23;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: counts 0..MAX on en, wraps to 0 with carry.
// clr has priority over en.
module bcd_digit_counter #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] TOP = W'(MAX);

    assign carry = en && (q == TOP);

    // Digit register: clear, wrap at TOP, or step by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (q == TOP) begin
                q <= '0;
            end else begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour BCD hh:mm:ss time-of-day counter with set modes.
// Hour wrap and mode-based carry gating live here.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int HOURS_MAX = HOURS_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic [1:0] mode,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [1:0] hr_tens,
    output logic       day_wrap
);

    localparam logic [1:0] HR_TENS_TOP = 2'(HOURS_MAX / 10);
    localparam logic [3:0] HR_ONES_TOP = 4'(HOURS_MAX % 10);

    logic inc_prev;
    logic ev;
    logic ev_run;
    logic ev_min;
    logic ev_hr;

    logic s0_c;
    logic s1_c;
    logic m0_c;
    logic m1_c;
    logic h0_c;
    logic h1_c;

    logic hr_step;
    logic hr_at_max;
    logic hr_wrap;
    logic hr_clr;

    assign ev     = inc & ~inc_prev;
    assign ev_run = ev & (mode == MODE_RUN);
    assign ev_min = ev & (mode == MODE_SET_MIN);
    assign ev_hr  = ev & (mode == MODE_SET_HR);

    // Minute carry reaches the hours only while running.
    assign hr_step   = (ev_run & m1_c) | ev_hr;
    assign hr_at_max = (hr_tens == HR_TENS_TOP)
                    && (hr_ones == HR_ONES_TOP);
    assign hr_wrap   = hr_step & hr_at_max;
    // Tens carry is unreachable; clearing on it keeps hours legal anyway.
    assign hr_clr    = hr_wrap | h1_c;

    bcd_digit_counter #(.MAX(DIGIT_MAX), .W(4)) u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .en    (ev_run),
        .clr   (ev_min),
        .q     (sec_ones),
        .carry (s0_c)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX), .W(3)) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .en    (s0_c),
        .clr   (ev_min),
        .q     (sec_tens),
        .carry (s1_c)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX), .W(4)) u_min_ones (
        .clk   (clk),
        .rst   (rst),
        .en    (ev_min | s1_c),
        .clr   (1'b0),
        .q     (min_ones),
        .carry (m0_c)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX), .W(3)) u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .en    (m0_c),
        .clr   (1'b0),
        .q     (min_tens),
        .carry (m1_c)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX), .W(4)) u_hr_ones (
        .clk   (clk),
        .rst   (rst),
        .en    (hr_step),
        .clr   (hr_clr),
        .q     (hr_ones),
        .carry (h0_c)
    );

    bcd_digit_counter #(.MAX(HOURS_MAX / 10), .W(2)) u_hr_tens (
        .clk   (clk),
        .rst   (rst),
        .en    (h0_c),
        .clr   (hr_clr),
        .q     (hr_tens),
        .carry (h1_c)
    );

    // Edge-detect history and the registered end-of-day pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_prev <= 1'b1;
            day_wrap <= 1'b0;
        end else begin
            inc_prev <= inc;
            day_wrap <= ev_run & hr_wrap;
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter.
// Expected times are hand-computed constants.
module tb_clock_time_counter;
    import clock_pkg::*;

    logic       clk;
    logic       rst;
    logic       inc;
    logic [1:0] mode;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic [3:0] hr_ones;
    logic [1:0] hr_tens;
    logic       day_wrap;

    int total = 0;
    int bad   = 0;

    clock_time_counter dut (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .mode     (mode),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .hr_ones  (hr_ones),
        .hr_tens  (hr_tens),
        .day_wrap (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] hms(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] tod();
        return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs,
                       input logic [19:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inc = 1'b1;
            @(negedge clk);
            inc = 1'b0;
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        mode = m;
    endtask

    initial begin
        rst  = 1'b1;
        inc  = 1'b1;
        mode = MODE_RUN;
        #1;
        chk("reset_time", tod(), hms(0, 0, 0));
        chk("reset_wrap", {19'd0, day_wrap}, 20'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("inc_high_at_release", tod(), hms(0, 0, 0));
        inc = 1'b0;
        pulses(1);
        chk("first_count", tod(), hms(0, 0, 1));

        set_mode(MODE_SET_HR);
        pulses(19);
        chk("set_hr_19", tod(), hms(19, 0, 1));
        set_mode(MODE_SET_MIN);
        pulses(59);
        chk("set_min_59", tod(), hms(19, 59, 0));
        set_mode(MODE_RUN);
        pulses(59);
        chk("run_19_59_59", tod(), hms(19, 59, 59));
        pulses(1);
        chk("carry_19_to_20", tod(), hms(20, 0, 0));

        set_mode(MODE_SET_HR);
        pulses(3);
        set_mode(MODE_SET_MIN);
        pulses(59);
        set_mode(MODE_RUN);
        pulses(58);
        chk("preload_23_59_58", tod(), hms(23, 59, 58));
        pulses(1);
        chk("run_23_59_59", tod(), hms(23, 59, 59));
        chk("no_wrap_yet", {19'd0, day_wrap}, 20'd0);
        pulses(1);
        chk("day_wrap_time", tod(), hms(0, 0, 0));
        chk("day_wrap_high", {19'd0, day_wrap}, 20'd1);
        @(negedge clk);
        chk("day_wrap_one_cycle", {19'd0, day_wrap}, 20'd0);

        set_mode(MODE_SET_HR);
        pulses(10);
        set_mode(MODE_SET_MIN);
        pulses(59);
        set_mode(MODE_RUN);
        pulses(37);
        chk("preload_10_59_37", tod(), hms(10, 59, 37));
        set_mode(MODE_SET_MIN);
        pulses(1);
        chk("set_min_no_hr_carry", tod(), hms(10, 0, 0));

        pulses(15);
        set_mode(MODE_RUN);
        pulses(42);
        set_mode(MODE_SET_HR);
        pulses(13);
        chk("preload_23_15_42", tod(), hms(23, 15, 42));
        pulses(1);
        chk("set_hr_wrap", tod(), hms(0, 15, 42));
        chk("set_hr_no_day_wrap", {19'd0, day_wrap}, 20'd0);
        pulses(9);
        set_mode(MODE_SET_MIN);
        pulses(45);
        chk("preload_09_00_00", tod(), hms(9, 0, 0));
        set_mode(MODE_SET_HR);
        pulses(1);
        chk("set_hr_09_to_10", tod(), hms(10, 0, 0));

        set_mode(MODE_HOLD);
        pulses(10);
        chk("hold_ignores", tod(), hms(10, 0, 0));
        @(negedge clk);
        mode = MODE_RUN;
        inc  = 1'b1;
        @(negedge clk);
        inc  = 1'b0;
        chk("mode_change_same_edge", tod(), hms(10, 0, 1));

        @(negedge clk);
        inc = 1'b1;
        repeat (100) @(negedge clk);
        chk("held_inc_one_step", tod(), hms(10, 0, 2));
        inc = 1'b0;
        pulses(1);
        chk("after_held_inc", tod(), hms(10, 0, 3));

        @(posedge clk);
        inc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_time", tod(), hms(0, 0, 0));
        chk("async_reset_wrap", {19'd0, day_wrap}, 20'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_inc_high", tod(), hms(0, 0, 0));
        inc = 1'b0;
        pulses(2);
        chk("post_reset_count", tod(), hms(0, 0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
